// File: rtl/interrupt_sequencer_pkg.sv
// irq_seq_pkg: shared types and defaults for the interrupt-entry sequencer.
// The state enum covers the whole entry sequence; the constants give the
// default vector location, drain depth and the zero padding used when the
// condition codes are pushed as a full stack word.
package irq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_CCR,
    VEC_LO,
    VEC_HI,
    LOAD
  } irq_state_e;

  localparam int          DEF_DRAIN_CYCLES = 3;
  localparam logic [11:0] DEF_VEC_ADDR     = 12'h000;
  localparam int          PUSH_W           = 16;
  localparam int          DEF_CCR_W        = 3;
  localparam int          CCR_PAD_W        = PUSH_W - DEF_CCR_W;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: stack-push and vector-read handshakes between the
// sequencer (master) and the memory stage (slave).
interface interrupt_sequencer_if;
  import irq_seq_pkg::*;

  logic              push_req;
  logic [PUSH_W-1:0] push_data;
  logic              push_ack;
  logic              vec_req;
  logic [11:0]       vec_addr;
  logic              vec_ack;
  logic [15:0]       vec_data;

  modport master (
    output push_req, push_data, vec_req, vec_addr,
    input  push_ack, vec_ack, vec_data
  );

  modport slave (
    input  push_req, push_data, vec_req, vec_addr,
    output push_ack, vec_ack, vec_data
  );

endinterface

// File: rtl/interrupt_sequencer_edge_latch.sv
// irq_edge_latch: rising-edge detect on the interrupt line plus a single
// pending flag. Further rises while pending merge into the one request.
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic accept,
  output logic pending
);

  logic irq_prev;
  logic rise;

  assign rise = irq_in & ~irq_prev;

  // Track the previous line level so a held line requests entry only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_prev <= 1'b0;
    else     irq_prev <= irq_in;
  end

  // A rise wins over acceptance so a request landing on the accept edge survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pending <= 1'b0;
    else if (rise)   pending <= 1'b1;
    else if (accept) pending <= 1'b0;
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: interrupt-entry controller sitting beside IF/ID.
// Freezes fetch, drains in-flight instructions, pushes PC high, PC low and
// CCR through the memory-stage stack port, reads the 32-bit handler vector,
// then pulses a fetch-PC load.
// Build option: define IRQ_NEST_EN to allow entry while a handler is active.
module interrupt_sequencer
  import irq_seq_pkg::*;
#(
  parameter int          PC_W         = 32,
  parameter int          CCR_W        = DEF_CCR_W,
  parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter logic [11:0] VEC_ADDR     = DEF_VEC_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq_in,
  input  logic                  rti_done_in,
  input  logic [PC_W-1:0]       pc_in,
  input  logic [CCR_W-1:0]      ccr_in,
  input  logic                  stall_in,
  input  logic                  redirect_in,
  output logic                  freeze_fetch,
  output logic                  inject_nop,
  interrupt_sequencer_if.master mem,
  output logic                  pc_load,
  output logic [PC_W-1:0]       pc_load_value,
  output logic                  in_isr,
  output logic                  busy
);

  localparam logic [2:0]  DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  localparam logic [11:0] VEC_ADDR_HI = VEC_ADDR + 12'd1;

  irq_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [PC_W-1:0]  ret_pc;
  logic [CCR_W-1:0] ret_ccr;
  logic [15:0]      vec_lo, vec_hi;
  logic             pending;
  logic             isr_block;
  logic             accept;

`ifdef IRQ_NEST_EN
  assign isr_block = 1'b0;
`else
  assign isr_block = in_isr;
`endif

  assign accept = (state_q == IDLE) & pending & ~stall_in & ~redirect_in & ~isr_block;
  assign busy   = (state_q != IDLE);
  assign pc_load_value = PC_W'({vec_hi, vec_lo});

  irq_edge_latch u_edge (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .accept  (accept),
    .pending (pending)
  );

  // State and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Return state is snapshotted on the acceptance edge; vector halves as they arrive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_pc  <= '0;
      ret_ccr <= '0;
      vec_lo  <= '0;
      vec_hi  <= '0;
    end else begin
      if (accept) begin
        ret_pc  <= pc_in;
        ret_ccr <= ccr_in;
      end
      if (state_q == VEC_LO && mem.vec_ack) vec_lo <= mem.vec_data;
      if (state_q == VEC_HI && mem.vec_ack) vec_hi <= mem.vec_data;
    end
  end

  // Handler-active flag: set as the PC is loaded, cleared by RTI completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 in_isr <= 1'b0;
    else if (state_q == LOAD) in_isr <= 1'b1;
    else if (rti_done_in)    in_isr <= 1'b0;
  end

  // Next-state and Moore outputs; each handshake state waits for its ack
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    freeze_fetch  = 1'b0;
    inject_nop    = 1'b0;
    mem.push_req  = 1'b0;
    mem.push_data = '0;
    mem.vec_req   = 1'b0;
    mem.vec_addr  = '0;
    pc_load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == 3'd0) state_d = PUSH_PCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      PUSH_PCH: begin
        mem.push_req  = 1'b1;
        mem.push_data = ret_pc[PC_W-1 -: 16];
        if (mem.push_ack) state_d = PUSH_PCL;
      end
      PUSH_PCL: begin
        mem.push_req  = 1'b1;
        mem.push_data = ret_pc[15:0];
        if (mem.push_ack) state_d = PUSH_CCR;
      end
      PUSH_CCR: begin
        mem.push_req  = 1'b1;
        mem.push_data = {{CCR_PAD_W{1'b0}}, ret_ccr};
        if (mem.push_ack) state_d = VEC_LO;
      end
      VEC_LO: begin
        mem.vec_req  = 1'b1;
        mem.vec_addr = VEC_ADDR;
        if (mem.vec_ack) state_d = VEC_HI;
      end
      VEC_HI: begin
        mem.vec_req  = 1'b1;
        mem.vec_addr = VEC_ADDR_HI;
        if (mem.vec_ack) state_d = LOAD;
      end
      LOAD: begin
        pc_load = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      freeze_fetch = 1'b1;
      inject_nop   = 1'b1;
    end
  end

endmodule
